// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with tree pseudo-LRU replacement,
// per-thread fetch PCs, in-order line fill with error detection, and flush.
module icache_assoc #(
  parameter  int tag_width_p           = 12,
  parameter  int entries_p             = 1024,
  parameter  int block_size_in_words_p = 4,
  parameter  int ways_p                = 2,
  parameter  int threads_p             = 2,
  localparam int sets_lp     = entries_p / (block_size_in_words_p * ways_p),
  localparam int set_w_lp    = $clog2(sets_lp),
  localparam int off_w_lp    = $clog2(block_size_in_words_p),
  localparam int pc_width_lp = tag_width_p + set_w_lp + off_w_lp,
  localparam int way_w_lp    = $clog2(ways_p),
  localparam int thr_w_lp    = $clog2(threads_p),
  localparam int line_w_lp   = 32 * block_size_in_words_p
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   v_i,
  input  logic                   w_i,
  input  logic                   flush_i,
  input  logic                   read_pc_plus4_i,
  input  logic [thr_w_lp-1:0]    thread_id_i,
  input  logic [pc_width_lp-1:0] w_pc_i,
  input  logic [31:0]            w_instr_i,
  input  logic [pc_width_lp-1:0] pc_i,
  output logic [31:0]            instr_o,
  output logic [pc_width_lp-1:0] pc_r_o,
  output logic [thr_w_lp-1:0]    thread_r_o,
  output logic [way_w_lp-1:0]    hit_way_o,
  output logic                   miss_o,
  output logic                   fill_busy_o,
  output logic                   fill_err_o,
  output logic                   flush_r_o
);

  // Tree bits are heap-ordered; a 0 bit means the LRU side is the left child.
  function automatic logic [way_w_lp-1:0] plru_victim(input logic [ways_p-2:0] bits);
    logic [ways_p-1:0] t;
    int                node;
    logic              b;
    t           = {1'b0, bits};
    node        = 0;
    plru_victim = '0;
    for (int l = 0; l < way_w_lp; l++) begin
      b                           = t[node[way_w_lp-1:0]];
      plru_victim[way_w_lp-1-l]   = b;
      node                        = 2 * node + 1 + int'(b);
    end
  endfunction

  function automatic logic [ways_p-2:0] plru_away(input logic [ways_p-2:0] bits,
                                                  input logic [way_w_lp-1:0] way);
    logic [ways_p-1:0] t;
    int                node;
    logic              dir;
    t    = {1'b0, bits};
    node = 0;
    for (int l = 0; l < way_w_lp; l++) begin
      dir                   = way[way_w_lp-1-l];
      t[node[way_w_lp-1:0]] = ~dir;
      node                  = 2 * node + 1 + int'(dir);
    end
    plru_away = t[ways_p-2:0];
  endfunction

  logic [pc_width_lp-1:0] pc_r_q [threads_p];
  logic [thr_w_lp-1:0]    thread_r_q;
  logic                   rd_v_q, rd_new_q, flush_r_q, fill_err_q;
  logic [off_w_lp-1:0]    count_q;
  logic [ways_p-1:0]      valid_q [sets_lp];
  logic [ways_p-2:0]      plru_q  [sets_lp];
  logic [ways_p-1:0]      rd_valid_q;
  logic [line_w_lp-1:0]   rd_line_q [ways_p];
  logic [tag_width_p-1:0] rd_tag_q  [ways_p];

  logic [line_w_lp-1:0]   data_mem [ways_p][sets_lp];
  logic [tag_width_p-1:0] tag_mem  [ways_p][sets_lp];
  logic [31:0]            buf_q    [block_size_in_words_p];

  logic rd_req, fill_req;
  assign rd_req   = v_i & ~w_i;
  assign fill_req = v_i & w_i;

  logic [set_w_lp-1:0]    r_set, w_set, cur_set;
  logic [off_w_lp-1:0]    w_off, cur_off;
  logic [tag_width_p-1:0] w_tag, cur_tag;
  logic [pc_width_lp-1:0] cur_pc;

  assign r_set   = pc_i[off_w_lp +: set_w_lp];
  assign w_tag   = w_pc_i[pc_width_lp-1 -: tag_width_p];
  assign w_set   = w_pc_i[off_w_lp +: set_w_lp];
  assign w_off   = w_pc_i[off_w_lp-1:0];
  assign cur_pc  = pc_r_q[thread_r_q];
  assign cur_tag = cur_pc[pc_width_lp-1 -: tag_width_p];
  assign cur_set = cur_pc[off_w_lp +: set_w_lp];
  assign cur_off = cur_pc[off_w_lp-1:0];

  // A sequential fetch within the same line by the same thread reuses the
  // array output latches, which still hold that line.
  logic suppress, rd_en;
  assign suppress = read_pc_plus4_i & (thread_id_i == thread_r_q) & (cur_off != '1);
  assign rd_en    = rd_req & ~suppress;

  logic fill_err, fill_last, install;
  assign fill_err  = fill_req & (w_off != count_q);
  assign fill_last = fill_req & ~fill_err & (w_off == '1);
  assign install   = fill_last & ~flush_i;

  logic [way_w_lp-1:0]  victim, hit_way;
  logic                 any_hit;
  logic [line_w_lp-1:0] fill_line, hit_line;
  logic [31:0]          instr;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    victim = plru_victim(plru_q[w_set]);
    for (int w = ways_p - 1; w >= 0; w--)
      if (!valid_q[w_set][w]) victim = way_w_lp'(w);

    fill_line = '0;
    for (int i = 0; i < block_size_in_words_p - 1; i++)
      fill_line[i*32 +: 32] = buf_q[i];
    fill_line[(block_size_in_words_p-1)*32 +: 32] = w_instr_i;

    hit_way = '0;
    any_hit = 1'b0;
    for (int w = ways_p - 1; w >= 0; w--)
      if (rd_valid_q[w] && (rd_tag_q[w] == cur_tag)) begin
        hit_way = way_w_lp'(w);
        any_hit = 1'b1;
      end
    hit_line = rd_line_q[hit_way];
    instr    = '0;
    for (int i = 0; i < block_size_in_words_p; i++)
      if (cur_off == off_w_lp'(i)) instr = hit_line[i*32 +: 32];
  end

  // NOTE: array contents and the fill buffer carry no reset; valid bits and
  // the fill count decide whether anything stored there is ever used.
  always_ff @(posedge clk_i) begin
    for (int w = 0; w < ways_p; w++)
      if (install && (victim == way_w_lp'(w))) begin
        data_mem[w][w_set] <= fill_line;
        tag_mem[w][w_set]  <= w_tag;
      end
    if (fill_req && (w_off != '1) && (!fill_err || (w_off == '0)))
      buf_q[w_off] <= w_instr_i;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int t = 0; t < threads_p; t++) pc_r_q[t] <= '0;
      for (int s = 0; s < sets_lp; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
      for (int w = 0; w < ways_p; w++) begin
        rd_line_q[w] <= '0;
        rd_tag_q[w]  <= '0;
      end
      rd_valid_q <= '0;
      thread_r_q <= '0;
      rd_v_q     <= 1'b0;
      rd_new_q   <= 1'b0;
      flush_r_q  <= 1'b0;
      fill_err_q <= 1'b0;
      count_q    <= '0;
    end else begin
      rd_new_q   <= rd_req;
      flush_r_q  <= rd_req ? 1'b0 : flush_i;
      fill_err_q <= fill_err;

      if (rd_req) begin
        pc_r_q[thread_id_i] <= pc_i;
        thread_r_q          <= thread_id_i;
        rd_v_q              <= 1'b1;
      end
      if (rd_en) begin
        rd_valid_q <= valid_q[r_set];
        for (int w = 0; w < ways_p; w++) begin
          rd_line_q[w] <= data_mem[w][r_set];
          rd_tag_q[w]  <= tag_mem[w][r_set];
        end
      end

      if (flush_i)        count_q <= '0;
      else if (fill_err)  count_q <= (w_off == '0) ? off_w_lp'(1) : '0;
      else if (fill_last) count_q <= '0;
      else if (fill_req)  count_q <= count_q + off_w_lp'(1);

      // A fill in the same set as the presented hit overrides the hit update.
      if (rd_new_q && any_hit) plru_q[cur_set] <= plru_away(plru_q[cur_set], hit_way);
      if (install)             plru_q[w_set]   <= plru_away(plru_q[w_set], victim);

      if (flush_i) begin
        for (int s = 0; s < sets_lp; s++) valid_q[s] <= '0;
      end else if (install) begin
        valid_q[w_set][victim] <= 1'b1;
      end
    end
  end

  assign instr_o     = instr;
  assign pc_r_o      = cur_pc;
  assign thread_r_o  = thread_r_q;
  assign hit_way_o   = hit_way;
  assign miss_o      = rd_v_q & ~any_hit;
  assign fill_busy_o = (count_q != '0);
  assign fill_err_o  = fill_err_q;
  assign flush_r_o   = flush_r_q;

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc at default parameters (128 sets, 4-word
// lines, 2 ways, 2 threads, 21-bit word PCs).
module tb_icache_assoc;

  logic        clk, reset_n;
  logic        v, w, flush, plus4;
  logic        tid;
  logic [20:0] w_pc, pc;
  logic [31:0] w_instr;
  logic [31:0] instr;
  logic [20:0] pc_r;
  logic        thread_r, hit_way, miss, busy, ferr, flush_r;

  int total = 0;
  int bad   = 0;

  icache_assoc dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .w_i(w), .flush_i(flush),
    .read_pc_plus4_i(plus4), .thread_id_i(tid), .w_pc_i(w_pc),
    .w_instr_i(w_instr), .pc_i(pc), .instr_o(instr), .pc_r_o(pc_r),
    .thread_r_o(thread_r), .hit_way_o(hit_way), .miss_o(miss),
    .fill_busy_o(busy), .fill_err_o(ferr), .flush_r_o(flush_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] mkpc(input int tg, input int st, input int of);
    return 21'(tg * 512 + st * 4 + of);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [20:0] a, input logic [31:0] d, input logic fl);
    v = 1'b1; w = 1'b1; w_pc = a; w_instr = d; flush = fl;
    step();
    v = 1'b0; w = 1'b0; flush = 1'b0;
  endtask

  task automatic fill_line(input int tg, input int st, input logic [31:0] base);
    for (int i = 0; i < 4; i++) fill(mkpc(tg, st, i), base + 32'(i), 1'b0);
  endtask

  task automatic rd(input logic t, input logic [20:0] a, input logic p4);
    v = 1'b1; w = 1'b0; tid = t; pc = a; plus4 = p4;
    step();
    v = 1'b0; plus4 = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; v = 1'b0; w = 1'b0; flush = 1'b0; plus4 = 1'b0;
    tid = 1'b0; w_pc = '0; pc = '0; w_instr = '0;
    #3;
    check("rst_instr", instr, 0);
    check("rst_miss", miss, 0);
    check("rst_busy", busy, 0);
    check("rst_pc_r", pc_r, 0);
    check("rst_flush_r", flush_r, 0);
    #10 reset_n = 1'b1;
    step();

    // Basic fill of set 0 then read of word 2.
    fill(mkpc(0, 0, 0), 32'h13, 1'b0);
    check("busy_after_w0", busy, 1);
    fill(mkpc(0, 0, 1), 32'h93, 1'b0);
    fill(mkpc(0, 0, 2), 32'h113, 1'b0);
    fill(mkpc(0, 0, 3), 32'h193, 1'b0);
    check("busy_after_w3", busy, 0);
    rd(1'b0, mkpc(0, 0, 2), 1'b0);
    check("basic_instr", instr, 32'h113);
    check("basic_miss", miss, 0);
    check("basic_way", hit_way, 0);
    check("basic_pc_r", pc_r, 2);

    // Eviction: A->way0, B->way1, hit A, C must replace B.
    fill_line(1, 5, 32'hA00);
    fill_line(2, 5, 32'hB00);
    rd(1'b0, mkpc(1, 5, 1), 1'b0);
    check("evict_hitA", instr, 32'hA01);
    check("evict_hitA_way", hit_way, 0);
    step();
    check("hold_instr", instr, 32'hA01);
    fill_line(3, 5, 32'hC00);
    rd(1'b0, mkpc(2, 5, 0), 1'b0);
    check("evict_B_miss", miss, 1);
    rd(1'b0, mkpc(1, 5, 2), 1'b0);
    check("evict_A_miss", miss, 0);
    check("evict_A_instr", instr, 32'hA02);
    rd(1'b0, mkpc(3, 5, 3), 1'b0);
    check("evict_C_way", hit_way, 1);
    check("evict_C_instr", instr, 32'hC03);

    // Out-of-order fill: offsets 0,1,3.
    fill(mkpc(4, 9, 0), 32'h900, 1'b0);
    fill(mkpc(4, 9, 1), 32'h901, 1'b0);
    check("err_busy_pre", busy, 1);
    check("err_none_yet", ferr, 0);
    fill(mkpc(4, 9, 3), 32'h903, 1'b0);
    check("err_pulse", ferr, 1);
    check("err_busy_post", busy, 0);
    step();
    check("err_pulse_end", ferr, 0);
    rd(1'b0, mkpc(4, 9, 0), 1'b0);
    check("err_no_line", miss, 1);

    // Per-thread PCs and array-read suppression.
    fill_line(0, 4, 32'h400);
    rd(1'b0, 21'h10, 1'b0);
    check("thr0_instr", instr, 32'h400);
    rd(1'b1, 21'h40, 1'b0);
    check("thr1_pc_r", pc_r, 21'h40);
    check("thr1_thread", thread_r, 1);
    check("thr1_miss", miss, 1);
    rd(1'b0, 21'h11, 1'b1);
    check("thr_sw_instr", instr, 32'h401);
    check("thr_sw_miss", miss, 0);
    check("thr_sw_pc_r", pc_r, 21'h11);
    check("thr_sw_thread", thread_r, 0);
    rd(1'b0, 21'h12, 1'b1);
    check("supp_instr", instr, 32'h402);
    rd(1'b0, 21'h13, 1'b1);
    check("supp_instr3", instr, 32'h403);
    rd(1'b0, 21'h14, 1'b1);
    check("line_cross_miss", miss, 1);

    // Flush during last fill word of another line.
    fill(mkpc(7, 20, 0), 32'h700, 1'b0);
    fill(mkpc(7, 20, 1), 32'h701, 1'b0);
    fill(mkpc(7, 20, 2), 32'h702, 1'b0);
    fill(mkpc(7, 20, 3), 32'h703, 1'b1);
    check("flush_r_set", flush_r, 1);
    check("flush_busy", busy, 0);
    step();
    check("flush_r_clr", flush_r, 0);
    rd(1'b0, mkpc(0, 0, 2), 1'b0);
    check("flush_old_miss", miss, 1);
    rd(1'b0, mkpc(7, 20, 0), 1'b0);
    check("flush_new_miss", miss, 1);

    // Asynchronous reset in the middle of a fill.
    fill_line(1, 5, 32'hA00);
    fill(mkpc(2, 30, 0), 32'h300, 1'b0);
    fill(mkpc(2, 30, 1), 32'h301, 1'b0);
    check("mid_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_instr", instr, 0);
    check("arst_miss", miss, 0);
    check("arst_pc_r", pc_r, 0);
    #1 reset_n = 1'b1;
    step();
    fill(mkpc(2, 30, 2), 32'h302, 1'b0);
    check("arst_resume_err", ferr, 1);
    fill(mkpc(2, 30, 3), 32'h303, 1'b0);
    rd(1'b0, mkpc(2, 30, 0), 1'b0);
    check("arst_partial_miss", miss, 1);
    rd(1'b0, mkpc(1, 5, 0), 1'b0);
    check("arst_line_miss", miss, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
